// File: rtl/u_csamul_acc_if.sv
// Handshake bundle between the carry-save multiplier output, the frame
// accumulator and the downstream consumer of frame totals.
interface u_csamul_acc_if #(
  parameter int N         = 4,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic               start;
  logic               clear;
  logic [2*N-1:0]     prod_in;
  logic               prod_valid;
  logic               prod_ready;
  logic [ACC_W-1:0]   acc_out;
  logic               acc_valid;
  logic               acc_ready;
  logic               overflow;
  logic [CNT_W-1:0]   count;

  modport master (
    output start, clear, prod_in, prod_valid, acc_ready,
    input  prod_ready, acc_out, acc_valid, overflow, count
  );

  modport slave (
    input  start, clear, prod_in, prod_valid, acc_ready,
    output prod_ready, acc_out, acc_valid, overflow, count
  );
endinterface

// File: rtl/u_csamul_acc.sv
// Frame accumulator for unsigned multiplier products: sums FRAME_LEN accepted
// products with saturation and holds the total until the consumer takes it.
module u_csamul_acc #(
  parameter int N         = 4,
  parameter int ACC_W     = 12,
  parameter int FRAME_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  u_csamul_acc_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_count;
  logic               r_prod_ready;
  logic               r_acc_valid;

  logic [ACC_W:0]     w_sum;
  logic               w_accept;
  logic               w_sat;

  // One extra bit catches the carry; once saturated the frame stays pinned.
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - 2*N){1'b0}}, bus.prod_in};
  assign w_accept = bus.prod_valid & r_prod_ready;
  assign w_sat    = w_sum[ACC_W] | r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_count      <= '0;
      r_prod_ready <= 1'b0;
      r_acc_valid  <= 1'b0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_ovf        <= 1'b0;
      r_count      <= '0;
      r_prod_ready <= 1'b0;
      r_acc_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_ACC;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_count      <= '0;
            r_prod_ready <= 1'b1;
          end
        end
        S_ACC: begin
          if (w_accept) begin
            r_acc   <= w_sat ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            r_ovf   <= w_sat;
            r_count <= r_count + CNT_W'(1);
            if (r_count == LAST_CNT) begin
              r_state      <= S_DONE;
              r_prod_ready <= 1'b0;
              r_acc_valid  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (bus.acc_ready) begin
            r_state     <= S_IDLE;
            r_acc_valid <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_prod_ready <= 1'b0;
          r_acc_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prod_ready = r_prod_ready;
  assign bus.acc_out    = r_acc;
  assign bus.acc_valid  = r_acc_valid;
  assign bus.overflow   = r_ovf;
  assign bus.count      = r_count;
endmodule

// File: tb/tb_u_csamul_acc.sv
// Scoreboard bench for u_csamul_acc: three instances cover the default frame,
// a narrow saturating accumulator and single-product frames.
module tb_u_csamul_acc;
  logic clk;
  logic rst_n_a, rst_n_b, rst_n_c;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] acc;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  u_csamul_acc_if #(.N(4), .ACC_W(12), .FRAME_LEN(4)) ifa ();
  u_csamul_acc_if #(.N(4), .ACC_W(10), .FRAME_LEN(5)) ifb ();
  u_csamul_acc_if #(.N(4), .ACC_W(12), .FRAME_LEN(1)) ifc ();

  u_csamul_acc #(.N(4), .ACC_W(12), .FRAME_LEN(4)) u_dut_a (.clk(clk), .rst_n(rst_n_a), .bus(ifa));
  u_csamul_acc #(.N(4), .ACC_W(10), .FRAME_LEN(5)) u_dut_b (.clk(clk), .rst_n(rst_n_b), .bus(ifb));
  u_csamul_acc #(.N(4), .ACC_W(12), .FRAME_LEN(1)) u_dut_c (.clk(clk), .rst_n(rst_n_c), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start pulse and product offer, one copy per instance.
  `define DEF_DRIVE(START_T, SEND_T, IFX, LBL) \
  task automatic START_T(); \
    @(posedge clk); #1 IFX.start = 1'b1; \
    @(posedge clk); #1 IFX.start = 1'b0; \
  endtask \
  task automatic SEND_T(input logic [7:0] v); \
    int t; \
    t = 0; \
    IFX.prod_in = v; \
    IFX.prod_valid = 1'b1; \
    @(negedge clk); \
    while (!IFX.prod_ready && t < 20) begin @(negedge clk); t++; end \
    if (!IFX.prod_ready) begin \
      n_vec++; n_err++; \
      $display("FAIL %s_send_timeout: prod_ready stayed 0, required 1", LBL); \
    end \
    @(posedge clk); #1 IFX.prod_valid = 1'b0; \
  endtask

  `DEF_DRIVE(a_start, a_send, ifa, "A")
  `DEF_DRIVE(b_start, b_send, ifb, "B")
  `DEF_DRIVE(c_start, c_send, ifc, "C")
  `undef DEF_DRIVE

  // Monitors: pop and compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    if (rst_n_a && ifa.acc_valid && ifa.acc_ready) begin
      if (q_a.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL A_unexpected: acc_out=%0d presented, none expected", ifa.acc_out);
      end else begin
        e_a = q_a.pop_front();
        check("A_acc_out", int'(ifa.acc_out), int'(e_a.acc));
        check("A_overflow", int'(ifa.overflow), int'(e_a.ovf));
        $display("txn A acc_out=%0d overflow=%0b", ifa.acc_out, ifa.overflow);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_b && ifb.acc_valid && ifb.acc_ready) begin
      if (q_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL B_unexpected: acc_out=%0d presented, none expected", ifb.acc_out);
      end else begin
        e_b = q_b.pop_front();
        check("B_acc_out", int'(ifb.acc_out), int'(e_b.acc));
        check("B_overflow", int'(ifb.overflow), int'(e_b.ovf));
        $display("txn B acc_out=%0d overflow=%0b", ifb.acc_out, ifb.overflow);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n_c && ifc.acc_valid && ifc.acc_ready) begin
      if (q_c.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL C_unexpected: acc_out=%0d presented, none expected", ifc.acc_out);
      end else begin
        e_c = q_c.pop_front();
        check("C_acc_out", int'(ifc.acc_out), int'(e_c.acc));
        check("C_overflow", int'(ifc.overflow), int'(e_c.ovf));
        $display("txn C acc_out=%0d overflow=%0b", ifc.acc_out, ifc.overflow);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    ifa.start = 0; ifa.clear = 0; ifa.prod_in = 0; ifa.prod_valid = 0; ifa.acc_ready = 0;
    ifb.start = 0; ifb.clear = 0; ifb.prod_in = 0; ifb.prod_valid = 0; ifb.acc_ready = 0;
    ifc.start = 0; ifc.clear = 0; ifc.prod_in = 0; ifc.prod_valid = 0; ifc.acc_ready = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_prod_ready", int'(ifa.prod_ready), 0);
    check("rst_acc_out", int'(ifa.acc_out), 0);
    check("rst_acc_valid", int'(ifa.acc_valid), 0);
    check("rst_overflow", int'(ifa.overflow), 0);
    check("rst_count", int'(ifa.count), 0);
    check("rstB_prod_ready", int'(ifb.prod_ready), 0);
    check("rstC_acc_valid", int'(ifc.acc_valid), 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

    // Test 1: 15,30,45,60 back-to-back -> 150
    ifa.acc_ready = 1'b1;
    q_a.push_back(exp_t'{16'd150, 1'b0});
    a_start();
    check("t1_ready_in_acc", int'(ifa.prod_ready), 1);
    a_send(8'd15);
    a_send(8'd30);
    check("t1_running_sum", int'(ifa.acc_out), 45);
    check("t1_count2", int'(ifa.count), 2);
    a_send(8'd45);
    check("t1_not_valid_yet", int'(ifa.acc_valid), 0);
    a_send(8'd60);
    check("t1_valid_latency", int'(ifa.acc_valid), 1);
    check("t1_count4", int'(ifa.count), 4);
    check("t1_ready_done", int'(ifa.prod_ready), 0);
    @(posedge clk); #1;
    check("t1_idle_valid", int'(ifa.acc_valid), 0);
    check("t1_idle_keep", int'(ifa.acc_out), 150);

    // Test 2: 225 x4 with gaps, result held while acc_ready=0
    ifa.acc_ready = 1'b0;
    q_a.push_back(exp_t'{16'd900, 1'b0});
    a_start();
    for (int i = 0; i < 4; i++) begin
      a_send(8'd225);
      if (i < 3) begin
        ifa.prod_in = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_valid", int'(ifa.acc_valid), 1);
      check("t2_hold_out", int'(ifa.acc_out), 900);
    end
    @(posedge clk); #1 ifa.acc_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_idle_valid", int'(ifa.acc_valid), 0);
    check("t2_idle_ready", int'(ifa.prod_ready), 0);

    // Test 4: clear after two accepts with a product offered
    a_start();
    a_send(8'd5);
    a_send(8'd6);
    ifa.prod_in = 8'd7; ifa.prod_valid = 1'b1; ifa.clear = 1'b1;
    @(posedge clk); #1 ifa.clear = 1'b0; ifa.prod_valid = 1'b0;
    check("t4_clr_count", int'(ifa.count), 0);
    check("t4_clr_acc", int'(ifa.acc_out), 0);
    check("t4_clr_ready", int'(ifa.prod_ready), 0);
    check("t4_clr_valid", int'(ifa.acc_valid), 0);
    @(posedge clk); #1 ifa.start = 1'b1; ifa.clear = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0; ifa.clear = 1'b0;
    check("t4_clr_beats_start", int'(ifa.prod_ready), 0);
    q_a.push_back(exp_t'{16'd10, 1'b0});
    a_start();
    a_send(8'd1);
    a_send(8'd2);
    a_send(8'd3);
    a_send(8'd4);
    @(posedge clk); #1;

    // Test 5: asynchronous reset mid-frame
    a_start();
    a_send(8'd100);
    a_send(8'd50);
    #2 rst_n_a = 1'b0;
    #1;
    check("t5_async_acc", int'(ifa.acc_out), 0);
    check("t5_async_count", int'(ifa.count), 0);
    check("t5_async_ready", int'(ifa.prod_ready), 0);
    check("t5_async_valid", int'(ifa.acc_valid), 0);
    @(negedge clk) rst_n_a = 1'b1;
    q_a.push_back(exp_t'{16'd100, 1'b0});
    a_start();
    a_send(8'd10);
    a_send(8'd20);
    a_send(8'd30);
    a_send(8'd40);
    @(posedge clk); #1;

    // Test 3: ACC_W=10, FRAME_LEN=5 saturation and the exact-max boundary
    ifb.acc_ready = 1'b1;
    q_b.push_back(exp_t'{16'd1023, 1'b1});
    b_start();
    for (int i = 0; i < 5; i++) b_send(8'd225);
    @(posedge clk); #1;
    q_b.push_back(exp_t'{16'd1023, 1'b0});
    b_start();
    for (int i = 0; i < 4; i++) b_send(8'd225);
    b_send(8'd123);
    @(posedge clk); #1;

    // Test 6: FRAME_LEN=1, start in DONE ignored
    ifc.acc_ready = 1'b0;
    q_c.push_back(exp_t'{16'd200, 1'b0});
    c_start();
    c_send(8'd200);
    check("t6_valid", int'(ifc.acc_valid), 1);
    check("t6_out", int'(ifc.acc_out), 200);
    check("t6_count", int'(ifc.count), 1);
    @(posedge clk); #1 ifc.start = 1'b1;
    @(posedge clk); #1 ifc.start = 1'b0;
    check("t6_start_ignored_valid", int'(ifc.acc_valid), 1);
    check("t6_start_ignored_ready", int'(ifc.prod_ready), 0);
    ifc.acc_ready = 1'b1;
    @(posedge clk); #1;
    check("t6_idle_valid", int'(ifc.acc_valid), 0);
    check("t6_idle_ready", int'(ifc.prod_ready), 0);

    // Every expected result must have been consumed
    @(posedge clk); #1;
    check("qA_drained", q_a.size(), 0);
    check("qB_drained", q_b.size(), 0);
    check("qC_drained", q_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
